// File: rtl/conv_channel_acc_ctrl_pkg.sv
// Shared definitions for the channel-input accumulation sequencer: FSM state
// encoding and error-flag bit positions.
package conv_channel_acc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int ERR_W     = 3;
    localparam int ERR_OVF   = 0;
    localparam int ERR_UNF   = 1;
    localparam int ERR_PROTO = 2;

endpackage

// File: rtl/conv_pix_ch_counter.sv
// Pixel/channel position counter: pixel wraps into the channel index, channel
// wraps back to zero; last_o marks the final pixel of the final channel.
module conv_pix_ch_counter
    import conv_channel_acc_ctrl_pkg::*;
#(
    parameter int IMAGE_SIZE     = 65536,
    parameter int CHANNEL_NUM_IN = 3,
    parameter int POINTER_WIDTH  = $clog2(IMAGE_SIZE) + 1,
    parameter int CH_WIDTH       = $clog2(CHANNEL_NUM_IN) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_i,
    input  logic                     en_i,
    output logic [POINTER_WIDTH-1:0] pix_o,
    output logic [CH_WIDTH-1:0]      ch_o,
    output logic                     last_o
);

    localparam logic [POINTER_WIDTH-1:0] PIX_MAX = POINTER_WIDTH'(IMAGE_SIZE - 1);
    localparam logic [CH_WIDTH-1:0]      CH_MAX  = CH_WIDTH'(CHANNEL_NUM_IN - 1);

    logic [POINTER_WIDTH-1:0] pix_q, pix_d;
    logic [CH_WIDTH-1:0]      ch_q, ch_d;
    logic                     pix_wrap;

    assign pix_wrap = (pix_q == PIX_MAX);

    always_comb begin
        pix_d = pix_q;
        ch_d  = ch_q;
        if (clr_i) begin
            pix_d = '0;
            ch_d  = '0;
        end else if (en_i) begin
            if (pix_wrap) begin
                pix_d = '0;
                ch_d  = (ch_q == CH_MAX) ? '0 : ch_q + CH_WIDTH'(1);
            end else begin
                pix_d = pix_q + POINTER_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_q <= '0;
            ch_q  <= '0;
        end else begin
            pix_q <= pix_d;
            ch_q  <= ch_d;
        end
    end

    assign pix_o  = pix_q;
    assign ch_o   = ch_q;
    assign last_o = pix_wrap & (ch_q == CH_MAX);

endmodule

// File: rtl/conv_channel_acc_ctrl.sv
// Sequencer for the adder / partial-sum FIFO / zero-select accumulation path.
// Operand side and result side are tracked by independent position counters.
module conv_channel_acc_ctrl
    import conv_channel_acc_ctrl_pkg::*;
#(
    parameter int IMAGE_SIZE     = 65536,
    parameter int CHANNEL_NUM_IN = 3,
    parameter int POINTER_WIDTH  = $clog2(IMAGE_SIZE) + 1,
    parameter int CH_WIDTH       = $clog2(CHANNEL_NUM_IN) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                valid_in,
    input  logic                valid_add,
    input  logic                fifo_full,
    input  logic                fifo_empty,
    output logic                sel_zero,
    output logic                fifo_rd_en,
    output logic                fifo_wr_en,
    output logic                out_valid,
    output logic                busy,
    output logic                done,
    output logic [CH_WIDTH-1:0] in_ch,
    output logic [ERR_W-1:0]    err
);

    localparam logic [CH_WIDTH-1:0] CH_MAX = CH_WIDTH'(CHANNEL_NUM_IN - 1);

    state_e                   state_q, state_d;
    logic [ERR_W-1:0]         err_q, err_d;
    logic                     done_q, done_d;

    logic                     busy_w, run_w, start_acc;
    logic                     in_en, res_en, in_last, res_last;
    logic [POINTER_WIDTH-1:0] in_pix, res_pix;
    logic [CH_WIDTH-1:0]      in_ch_w, res_ch;
    logic                     unused_pix;

    assign busy_w    = (state_q != ST_IDLE);
    assign run_w     = (state_q == ST_RUN);
    assign start_acc = start & (state_q == ST_IDLE);
    assign in_en     = run_w & valid_in;
    assign res_en    = busy_w & valid_add;

    conv_pix_ch_counter #(
        .IMAGE_SIZE    (IMAGE_SIZE),
        .CHANNEL_NUM_IN(CHANNEL_NUM_IN),
        .POINTER_WIDTH (POINTER_WIDTH),
        .CH_WIDTH      (CH_WIDTH)
    ) u_in_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (start_acc),
        .en_i  (in_en),
        .pix_o (in_pix),
        .ch_o  (in_ch_w),
        .last_o(in_last)
    );

    conv_pix_ch_counter #(
        .IMAGE_SIZE    (IMAGE_SIZE),
        .CHANNEL_NUM_IN(CHANNEL_NUM_IN),
        .POINTER_WIDTH (POINTER_WIDTH),
        .CH_WIDTH      (CH_WIDTH)
    ) u_res_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (start_acc),
        .en_i  (res_en),
        .pix_o (res_pix),
        .ch_o  (res_ch),
        .last_o(res_last)
    );

    // Pixel positions are tracked for debug visibility; sequencing only needs last/ch.
    assign unused_pix = ^{in_pix, res_pix};

    assign sel_zero   = busy_w & (in_ch_w == '0);
    assign fifo_rd_en = in_en & (in_ch_w != '0);
    assign fifo_wr_en = res_en & (res_ch != CH_MAX);
    assign out_valid  = res_en & (res_ch == CH_MAX);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = start_acc ? '0 : err_q;
        err_d[ERR_OVF]   = err_d[ERR_OVF] | (fifo_wr_en & fifo_full);
        err_d[ERR_UNF]   = err_d[ERR_UNF] | (fifo_rd_en & fifo_empty);
        err_d[ERR_PROTO] = err_d[ERR_PROTO] | (valid_in & ~run_w) | (valid_add & ~busy_w);
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (in_en & in_last) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (res_en & res_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            err_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_w;
    assign done  = done_q;
    assign in_ch = in_ch_w;
    assign err   = err_q;

endmodule

// File: tb/tb_conv_channel_acc_ctrl.sv
// Directed bench: IMAGE_SIZE=4 with 3 channels (dut a) and 1 channel (dut b)
// share stimulus; the adder is a 5-cycle valid delay line.
module tb_conv_channel_acc_ctrl;

    logic clk = 1'b0;
    logic reset, start, valid_in, valid_add, fifo_full, fifo_empty;

    logic       a_sel, a_rd, a_wr, a_ov, a_busy, a_done;
    logic [2:0] a_in_ch;
    logic [2:0] a_err;
    logic       b_sel, b_rd, b_wr, b_ov, b_busy, b_done;
    logic [0:0] b_in_ch;
    logic [2:0] b_err;

    int   n_chk = 0;
    int   n_fail = 0;
    int   mode = 2;
    int   bi = 0;
    int   ri = 0;
    int   full_at = -1;
    int   empty_at = -1;
    logic last_pending = 1'b0;
    logic force_add = 1'b0;
    logic last_vin = 1'b0;
    logic [4:0] hist = '0;

    always #5 clk = ~clk;

    conv_channel_acc_ctrl #(.IMAGE_SIZE(4), .CHANNEL_NUM_IN(3)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .valid_in(valid_in),
        .valid_add(valid_add), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .sel_zero(a_sel), .fifo_rd_en(a_rd), .fifo_wr_en(a_wr), .out_valid(a_ov),
        .busy(a_busy), .done(a_done), .in_ch(a_in_ch), .err(a_err)
    );

    conv_channel_acc_ctrl #(.IMAGE_SIZE(4), .CHANNEL_NUM_IN(1)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .valid_in(valid_in),
        .valid_add(valid_add), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .sel_zero(b_sel), .fifo_rd_en(b_rd), .fifo_wr_en(b_wr), .out_valid(b_ov),
        .busy(b_busy), .done(b_done), .in_ch(b_in_ch), .err(b_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int total_res();
        return (mode == 1) ? 4 : 12;
    endfunction

    task automatic score();
        logic s, r, w, o, bz, dn;
        int   tot;
        tot = total_res();
        s  = (mode == 1) ? b_sel  : a_sel;
        r  = (mode == 1) ? b_rd   : a_rd;
        w  = (mode == 1) ? b_wr   : a_wr;
        o  = (mode == 1) ? b_ov   : a_ov;
        bz = (mode == 1) ? b_busy : a_busy;
        dn = (mode == 1) ? b_done : a_done;
        check_eq($sformatf("busy@res%0d", ri), bz, ri < tot);
        check_eq($sformatf("done@res%0d", ri), dn, last_pending);
        last_pending = 1'b0;
        if (valid_in) begin
            check_eq($sformatf("sel_zero[%0d]", bi), s, bi < 4);
            check_eq($sformatf("fifo_rd_en[%0d]", bi), r, bi >= 4);
            bi++;
        end
        if (valid_add) begin
            check_eq($sformatf("fifo_wr_en[%0d]", ri), w, ri < tot - 4);
            check_eq($sformatf("out_valid[%0d]", ri), o, ri >= tot - 4);
            ri++;
            if (ri == tot) last_pending = 1'b1;
        end
    endtask

    // One clock: inputs driven at posedge+1, checked at posedge+2.
    task automatic cycle(input logic vin, input logic st);
        hist       = {hist[3:0], last_vin};
        last_vin   = vin;
        valid_in   = vin;
        start      = st;
        valid_add  = hist[4] | force_add;
        fifo_full  = valid_add && (mode != 2) && (ri == full_at);
        fifo_empty = vin && (mode != 2) && (bi == empty_at);
        #1;
        if (mode != 2) score();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input int m, input int gap, input int nbeats, input logic [2:0] dut_err_sel);
        mode = 2;
        cycle(1'b0, 1'b1);
        check_eq("err_clear_on_start", dut_err_sel[0] ? b_err : a_err, 3'b000);
        mode = m; bi = 0; ri = 0; last_pending = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            cycle(1'b1, 1'b0);
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && (ri < total_res() || last_pending); i++) cycle(1'b0, 1'b0);
        check_eq("drain_bound", (ri == total_res()) && !last_pending, 1);
        mode = 2;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; valid_in = 1'b0; valid_add = 1'b0;
        fifo_full = 1'b0; fifo_empty = 1'b0;
        #3;
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_done", a_done, 0);
        check_eq("rst_in_ch", a_in_ch, 0);
        check_eq("rst_err", a_err, 0);
        check_eq("rst_comb", {a_sel, a_rd, a_wr, a_ov}, 4'b0000);
        @(posedge clk); #1;
        reset = 1'b0;

        // Protocol violations while idle, then flush the adder pipe.
        force_add = 1'b1;
        cycle(1'b1, 1'b0);
        force_add = 1'b0;
        check_eq("proto_err", a_err, 3'b100);
        check_eq("proto_in_ch", a_in_ch, 0);
        check_eq("proto_busy", a_busy, 0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);

        // Nominal back-to-back pass.
        run_pass(0, 0, 12, 3'b000);
        wait_done();
        check_eq("nom_err", a_err, 3'b000);
        check_eq("nom_busy_after", a_busy, 0);

        // Gapped input: one beat every third cycle.
        run_pass(0, 2, 12, 3'b000);
        wait_done();
        check_eq("gap_err", a_err, 3'b000);

        // FIFO full on result 2, FIFO empty on operand beat 5.
        full_at = 2; empty_at = 5;
        run_pass(0, 0, 12, 3'b000);
        wait_done();
        full_at = -1; empty_at = -1;
        check_eq("fifo_err_sticky", a_err, 3'b011);

        // Reset mid-pass after beat 6.
        run_pass(0, 0, 7, 3'b000);
        mode = 2;
        valid_in = 1'b1; valid_add = 1'b1; reset = 1'b1;
        #1;
        check_eq("midrst_busy", a_busy, 0);
        check_eq("midrst_in_ch", a_in_ch, 0);
        check_eq("midrst_comb", {a_sel, a_rd, a_wr, a_ov}, 4'b0000);
        check_eq("midrst_err", a_err, 0);
        valid_in = 1'b0; valid_add = 1'b0; hist = '0; last_vin = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        run_pass(0, 0, 12, 3'b000);
        wait_done();
        check_eq("post_rst_err", a_err, 3'b000);

        // Single-channel build.
        run_pass(1, 0, 4, 3'b001);
        wait_done();
        check_eq("ch1_err", b_err, 3'b000);
        check_eq("ch1_busy_after", b_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
